// File: rtl/mem16_word_sequencer.sv
// ----------------------------------------------------------------------------
// mem16_word_sequencer: serialises word read/write requests into bit accesses
// on a 16x1 memory and reassembles the word. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem16_word_sequencer #(
  parameter int WORD_WIDTH      = 4,
  parameter int WORD_ADDR_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [WORD_ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0]      req_wdata,
  output logic                       rsp_valid,
  output logic [WORD_WIDTH-1:0]      rsp_rdata,
  output logic [3:0]                 mem_address,
  output logic                       mem_write_enable,
  output logic                       mem_set,
  input  logic                       mem_result
);

  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [WORD_WIDTH-1:0] r_shift;

  logic       w_last;
  logic       w_capture;
  logic [3:0] w_base;

  assign req_ready = (r_state == S_IDLE);
  assign w_last    = (r_cnt == CNT_W'(WORD_WIDTH - 1));
  assign w_base    = 4'(int'(req_addr) * WORD_WIDTH);
  // Memory result trails the address by one edge, so capture starts on the
  // second ISSUE edge and finishes on the DRAIN edge.
  assign w_capture = ((r_state == S_ISSUE) && (r_cnt != '0)) || (r_state == S_DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_write          <= 1'b0;
      r_wdata          <= '0;
      r_shift          <= '0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_set          <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (w_capture) begin
        r_shift <= {mem_result, r_shift[WORD_WIDTH-1:1]};
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_state          <= S_ISSUE;
            r_cnt            <= '0;
            r_write          <= req_write;
            r_wdata          <= req_wdata >> 1;
            mem_address      <= w_base;
            mem_write_enable <= req_write;
            mem_set          <= req_write & req_wdata[0];
          end
        end
        S_ISSUE: begin
          if (w_last) begin
            r_state          <= S_DRAIN;
            mem_write_enable <= 1'b0;
            mem_set          <= 1'b0;
          end else begin
            r_cnt       <= r_cnt + CNT_W'(1);
            mem_address <= mem_address + 4'd1;
            mem_set     <= r_write & r_wdata[0];
            r_wdata     <= r_wdata >> 1;
          end
        end
        S_DRAIN: begin
          r_state   <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= {mem_result, r_shift[WORD_WIDTH-1:1]};
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/mem16_word_sequencer.md
Name: mem16_word_sequencer

Overview:
- Word-wide access front-end for the 16x1 bit memories (ram16, or rom16 for reads).
- Accepts whole-word read/write requests from the datapath over a valid/ready handshake.
- Serialises each request into WORD_WIDTH single-bit accesses on the memory's address/write_enable/set/result pins, then returns the assembled word with a one-cycle response pulse.
- Sits directly upstream of the memory and is its only driver.

Parameters:
- WORD_WIDTH, 4, bits per word. WORD_WIDTH * 2^WORD_ADDR_WIDTH must equal 16.
- WORD_ADDR_WIDTH, 2, word address width.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high when the sequencer can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  WORD_ADDR_WIDTH  word address.
- req_wdata  input  WORD_WIDTH  write data; bit i is stored at memory bit req_addr*WORD_WIDTH+i.
- rsp_valid  output  1  one-cycle pulse; rsp_rdata valid.
- rsp_rdata  output  WORD_WIDTH  read data; for writes, the data written.
- mem_address  output  4  to memory address.
- mem_write_enable  output  1  to memory write_enable.
- mem_set  output  1  to memory set.
- mem_result  input  1  from memory result (registered, one-cycle latency; echoes set on a write).

Behaviour:
- Reset (rst_n low at a posedge):
  - State goes to IDLE.
  - mem_address, mem_write_enable, mem_set, rsp_valid and rsp_rdata go to 0.
  - Bit counter goes to 0.
  - No request is accepted while rst_n is low.
- req_ready = (state == IDLE), combinational from the state register. A request is accepted at a posedge where req_valid && req_ready && rst_n.
- On acceptance:
  - Latch req_write, base = req_addr*WORD_WIDTH, and req_wdata.
  - Subsequent changes on the req_* inputs are ignored.
- States:
  - IDLE: waits for a request.
  - ISSUE: one cycle per bit, WORD_WIDTH cycles in total.
  - DRAIN: one cycle.
  - Then return to IDLE.
- Let E0 be the acceptance edge and Ek the k-th edge after it.
  - After Ek, for k = 0..WORD_WIDTH-1: mem_address = base+k, mem_write_enable = latched write, mem_set = wdata[k] (0 for reads).
  - After E(WORD_WIDTH): state = DRAIN; mem_write_enable = 0; mem_address holds its last value.
- Capture:
  - At edges E2..E(WORD_WIDTH+1), mem_result is shifted into rdata bit positions 0..WORD_WIDTH-1 in order.
  - Reads and writes use the same capture path, because the memory echoes set during a write.
- Response:
  - After E(WORD_WIDTH+1): rsp_valid = 1 for exactly one cycle, rsp_rdata holds the complete word, state = IDLE.
  - Latency: rsp_valid is high in the cycle following edge E(WORD_WIDTH+1).
- Back-to-back:
  - req_ready is high during the rsp_valid cycle, so a new request can be accepted at the edge ending that cycle.
  - Maximum throughput: one request per WORD_WIDTH+2 cycles.
- rsp_rdata holds its value until the next response and is not cleared when rsp_valid drops.
- req_valid while busy: ignored and not queued. The requester must hold req_valid until it sees req_ready.
- Address arithmetic:
  - base + k never exceeds 15 for the default parameters.
  - mem_address is exactly 4 bits; no wrap is possible.
- Reset mid-operation:
  - Access aborts at the reset edge; mem_write_enable is 0 from the next cycle.
  - Bits already written remain in memory.
  - No rsp_valid for the aborted request.
  - req_ready is high from the first cycle rst_n is sampled high.
- mem_write_enable is never high outside ISSUE.

Test Plan:
- Read, no writes:
  - Stimulus: memory = rom16 (pattern 16'hAAAA); read addr 0.
  - Required: mem_address sequence 0,1,2,3 with mem_write_enable = 0 throughout.
  - Required: rsp_valid pulses 5 cycles after acceptance with rsp_rdata = 4'b1010.
  - Then read addr 3 -> rsp_rdata = 4'b1010.
- Write then read back:
  - Stimulus: on ram16, write 4'b1011 to addr 2, then read addr 2.
  - Required on the write: mem_address 8,9,10,11 with mem_set 1,1,0,1 and mem_write_enable high for exactly 4 cycles.
  - Required: the write response has rsp_rdata = 4'b1011; the read response also has rsp_rdata = 4'b1011.
- Back-to-back:
  - Stimulus: hold req_valid high continuously; write 0x1 to addr 0, write 0x2 to addr 1, write 0x4 to addr 2, write 0x8 to addr 3; then read addrs 3,2,1,0.
  - Required: acceptances exactly 6 cycles apart.
  - Required: read responses 0x8, 0x4, 0x2, 0x1.
- Busy-time stimulus:
  - Stimulus: change req_addr and req_wdata on every cycle while the sequencer is busy.
  - Required: no effect on the in-flight memory sequence.
  - Required: req_ready stays 0 from the cycle after acceptance until the rsp_valid cycle.
- Reset mid-write:
  - Stimulus: write 4'b1111 to addr 1 over memory initialised to 0; assert rst_n low at E2.
  - Required: no rsp_valid; mem_write_enable = 0 from the next cycle.
  - Required: a subsequent read of addr 1 returns 4'b0011.
- Reset values:
  - Stimulus: hold rst_n low for 3 cycles with req_valid = 1.
  - Required: no acceptance; rsp_valid = 0, mem_write_enable = 0, mem_address = 0, rsp_rdata = 0.
